// File: rtl/mv_result_collector.sv
// mv_result_collector: collects NI-element result bursts from the
// matrix-by-vector multiplier into a small first-word-fall-through FIFO,
// tags each burst with its block index and hands it downstream over a
// valid/ready handshake. done rises once every expected block has been popped.
// Optional build macro MVR_ZERO_PAD_EN: zero the unused trailing elements of
// the final block at push time (element 0 is the most significant slice).
module mv_result_collector #(
    parameter int element_width = 32,
    parameter int NI            = 8,
    parameter int DEPTH         = 4,
    parameter int ADDR_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 total_rows,
    input  logic [NI*element_width-1:0] in_data,
    input  logic                        in_valid,
    output logic [NI*element_width-1:0] out_data,
    output logic [ADDR_W-1:0]           out_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        overflow,
    output logic                        done
);
    localparam int DW    = NI * element_width;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_r, fsm_next_s, state_next_s;
    logic [BW-1:0]     nblk_r, pushed_r, popped_r;
    logic [BW-1:0]     nblk_calc_s, pushed_next_s, popped_next_s;
    logic              load_s, wr_en_s, rd_en_s, drop_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [CNT_W-1:0]  count_r, count_next_s;
    logic [DW-1:0]     mem_data_r [DEPTH];
    logic [ADDR_W-1:0] mem_addr_r [DEPTH];
    logic [DW-1:0]     push_data_s, head_data_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic              bypass_s, valid_next_s;
    logic [DW-1:0]     out_data_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              out_valid_r, out_last_r, overflow_r, done_r;

    // Block count is ceil(total_rows/NI) in 33 bits, kept to ADDR_W+1 bits.
    assign nblk_calc_s = BW'(({1'b0, total_rows} + 33'(NI - 1)) / 33'(NI));

`ifdef MVR_ZERO_PAD_EN
    logic [31:0] last_cnt_r;

    // Zero every element whose index is at or beyond the valid count.
    function automatic logic [DW-1:0] pad_burst(input logic [DW-1:0] data,
                                                input logic [31:0]   keep);
        logic [DW-1:0] res;
        res = data;
        for (int i = 0; i < NI; i++) begin
            res[DW-1-i*element_width -: element_width] =
                (32'(i) >= keep) ? {element_width{1'b0}}
                                 : data[DW-1-i*element_width -: element_width];
        end
        return res;
    endfunction

    // Number of valid elements in the final block, captured with nblk.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_cnt_r <= 32'd0;
        end else if (load_s) begin
            last_cnt_r <= total_rows - 32'((33'(nblk_calc_s) - 33'd1) * 33'(NI));
        end
    end

    // Pad only the final block as it enters the FIFO.
    always_comb begin
        push_data_s = in_data;
        if (pushed_r == nblk_r - BW'(1)) begin
            push_data_s = pad_burst(in_data, last_cnt_r);
        end else begin
            push_data_s = in_data;
        end
    end
`else
    assign push_data_s = in_data;
`endif

    // Next-state, push/pop decisions and block counters.
    always_comb begin
        fsm_next_s    = state_r;
        load_s        = 1'b0;
        wr_en_s       = 1'b0;
        rd_en_s       = 1'b0;
        drop_s        = 1'b0;
        pushed_next_s = pushed_r;
        popped_next_s = popped_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    fsm_next_s = (nblk_calc_s == '0) ? ST_DONE : ST_COLLECT;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                rd_en_s = out_valid_r && out_ready;
                if (in_valid && (pushed_r != nblk_r)) begin
                    if ((count_r == CNT_W'(DEPTH)) && !rd_en_s) begin
                        drop_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b1;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
                pushed_next_s = pushed_r + BW'(wr_en_s);
                popped_next_s = popped_r + BW'(rd_en_s);
                if (popped_next_s == nblk_r) begin
                    fsm_next_s = ST_DONE;
                end else if (pushed_next_s == nblk_r) begin
                    fsm_next_s = ST_DRAIN;
                end else begin
                    fsm_next_s = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                rd_en_s       = out_valid_r && out_ready;
                popped_next_s = popped_r + BW'(rd_en_s);
                if (popped_next_s == nblk_r) begin
                    fsm_next_s = ST_DONE;
                end else begin
                    fsm_next_s = ST_DRAIN;
                end
            end
            ST_DONE: fsm_next_s = ST_DONE;
            default: fsm_next_s = ST_IDLE;
        endcase
        state_next_s = start ? fsm_next_s : ST_IDLE;
    end

    // Next FIFO head; a push into an (effectively) empty FIFO bypasses memory.
    always_comb begin
        rd_ptr_next_s = rd_en_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        count_next_s  = count_r + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
        bypass_s      = wr_en_s && (wr_ptr_r == rd_ptr_next_s);
        head_data_s   = bypass_s ? push_data_s : mem_data_r[rd_ptr_next_s];
        head_addr_s   = bypass_s ? pushed_r[ADDR_W-1:0] : mem_addr_r[rd_ptr_next_s];
        valid_next_s  = (count_next_s != '0) &&
                        ((state_next_s == ST_COLLECT) || (state_next_s == ST_DRAIN));
    end

    // FIFO storage; each entry carries its block index.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_data_r[wr_ptr_r] <= push_data_s;
            mem_addr_r[wr_ptr_r] <= pushed_r[ADDR_W-1:0];
        end
    end

    // State, counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            nblk_r      <= '0;
            pushed_r    <= '0;
            popped_r    <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_addr_r  <= '0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (load_s) begin
                nblk_r     <= nblk_calc_s;
                pushed_r   <= '0;
                popped_r   <= '0;
                overflow_r <= 1'b0;
            end else begin
                pushed_r <= pushed_next_s;
                popped_r <= popped_next_s;
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
            if (!start) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                wr_ptr_r <= wr_en_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
                rd_ptr_r <= rd_ptr_next_s;
                count_r  <= count_next_s;
            end
            out_valid_r <= valid_next_s;
            out_data_r  <= valid_next_s ? head_data_s : '0;
            out_addr_r  <= valid_next_s ? head_addr_s : '0;
            out_last_r  <= valid_next_s && ({1'b0, head_addr_s} == nblk_r - BW'(1));
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    assign out_data   = out_data_r;
    assign out_addr   = out_addr_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign done       = done_r;
endmodule

// File: tb/tb_mv_result_collector.sv
// Directed testbench for mv_result_collector (NI=8, DEPTH=4, 32-bit elements).
module tb_mv_result_collector;
    localparam int EW = 32, NI = 8, DEPTH = 4, ADDR_W = 16, DW = EW * NI;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, out_ready;
    logic [31:0]       total_rows;
    logic [DW-1:0]     in_data, out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid, out_last, overflow, done;
    logic [2:0]        fifo_count;
    int                errors = 0;
    int                checks = 0;

    always #5 clk = ~clk;

    mv_result_collector #(.element_width(EW), .NI(NI), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .total_rows(total_rows),
        .in_data(in_data), .in_valid(in_valid), .out_data(out_data),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .fifo_count(fifo_count), .overflow(overflow), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input logic [7:0] tag);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++) r[DW-1-i*EW -: EW] = {tag, 24'(i)};
        return r;
    endfunction

    task automatic pulse(input logic [DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; total_rows = 32'd0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 16'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", out_addr); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        total_rows = 32'd16; out_ready = 1'b1; start = 1'b1;
        tick();
        pulse(mk(8'h10));
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %b expected 1", out_valid); end
        checks++; if (out_addr !== 16'd0) begin errors++; $display("FAIL basic_addr0: got %0d expected 0", out_addr); end
        checks++; if (out_data !== mk(8'h10)) begin errors++; $display("FAIL basic_data0: got %h expected %h", out_data, mk(8'h10)); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL basic_last0: got %b expected 0", out_last); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count0: got %0d expected 1", fifo_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped0: got %b expected 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b expected 0", done); end
        tick(); tick(); tick();
        pulse(mk(8'h11));
        checks++; if (out_addr !== 16'd1) begin errors++; $display("FAIL basic_addr1: got %0d expected 1", out_addr); end
        checks++; if (out_data !== mk(8'h11)) begin errors++; $display("FAIL basic_data1: got %h expected %h", out_data, mk(8'h11)); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL basic_last1: got %b expected 1", out_last); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_done: got %b expected 0", out_valid); end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_clear: got %b expected 0", done); end
    endtask

    task automatic test_overflow();
        int exp_cnt;
        total_rows = 32'd40; out_ready = 1'b0; start = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            pulse(mk(8'h20 + 8'(k)));
            exp_cnt = (k < 4) ? k + 1 : 4;
            checks++; if (fifo_count !== 3'(exp_cnt)) begin errors++; $display("FAIL ovf_count%0d: got %0d expected %0d", k, fifo_count, exp_cnt); end
            checks++; if (overflow !== (k == 4)) begin errors++; $display("FAIL ovf_flag%0d: got %b expected %b", k, overflow, (k == 4)); end
            checks++; if (out_data !== mk(8'h20)) begin errors++; $display("FAIL ovf_head%0d: got %h expected %h", k, out_data, mk(8'h20)); end
            tick();
        end
        out_ready = 1'b1;
        repeat (8) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ovf_no_done: got %b expected 0", done); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", fifo_count); end
        start = 1'b0;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_held: got %b expected 1", overflow); end
    endtask

    task automatic test_full_simultaneous();
        total_rows = 32'd40; out_ready = 1'b0; start = 1'b1;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_cleared: got %b expected 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            pulse(mk(8'h30 + 8'(k)));
            tick();
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        in_data = mk(8'h34); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_swap_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_swap_ovf: got %b expected 0", overflow); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid%0d: got %b expected 1", k, out_valid); end
            checks++; if (out_addr !== 16'(k)) begin errors++; $display("FAIL full_addr%0d: got %0d expected %0d", k, out_addr, k); end
            checks++; if (out_data !== mk(8'h30 + 8'(k))) begin errors++; $display("FAIL full_data%0d: got %h expected %h", k, out_data, mk(8'h30 + 8'(k))); end
            checks++; if (out_last !== (k == 4)) begin errors++; $display("FAIL full_last%0d: got %b expected %b", k, out_last, (k == 4)); end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", done); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_zero_rows();
        total_rows = 32'd0; start = 1'b1;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_hold: got %b expected 1", done); end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear: got %b expected 0", done); end
    endtask

    task automatic test_restart();
        total_rows = 32'd24; out_ready = 1'b1; start = 1'b1;
        tick();
        pulse(mk(8'h40));
        checks++; if (out_addr !== 16'd0) begin errors++; $display("FAIL rst_addr0: got %0d expected 0", out_addr); end
        tick();
        out_ready = 1'b0;
        pulse(mk(8'h41));
        checks++; if (out_addr !== 16'd1) begin errors++; $display("FAIL rst_addr1: got %0d expected 1", out_addr); end
        start = 1'b0;
        tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_flush: got %0d expected 0", fifo_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        start = 1'b1;
        tick();
        pulse(mk(8'h42));
        checks++; if (out_addr !== 16'd0) begin errors++; $display("FAIL rst_addr_restart: got %0d expected 0", out_addr); end
        checks++; if (out_data !== mk(8'h42)) begin errors++; $display("FAIL rst_data: got %h expected %h", out_data, mk(8'h42)); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rst_count: got %0d expected 1", fifo_count); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_zero_pad();
        logic [DW-1:0] ones, exp_last;
        ones = '1;
`ifdef MVR_ZERO_PAD_EN
        exp_last = {{(2*EW){1'b1}}, {(DW-2*EW){1'b0}}};
`else
        exp_last = '1;
`endif
        total_rows = 32'd10; out_ready = 1'b1; start = 1'b1;
        tick();
        pulse(ones);
        checks++; if (out_data !== ones) begin errors++; $display("FAIL pad_block0: got %h expected %h", out_data, ones); end
        tick();
        pulse(ones);
        checks++; if (out_data !== exp_last) begin errors++; $display("FAIL pad_block1: got %h expected %h", out_data, exp_last); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL pad_last: got %b expected 1", out_last); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pad_done: got %b expected 1", done); end
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_simultaneous();
        test_zero_rows();
        test_restart();
        test_zero_pad();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
